load_store_unit: RTL and testbench

CPU-side initiator for the data-memory interface: accepts one load or store per transaction from the execute stage, drives a word-aligned request with byte enables to the data memory, and waits for an acknowledge. Loads are returned to writeback with RISC-V lb/lh/lw/lbu/lhu lane extraction and sign or zero extension. Misaligned addresses, illegal funct3 values, conflicting commands and memory timeouts are reported as faults. The pipeline stalls on oBusy while a transaction is in flight.

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: issues one aligned load/store per command, waits for ack,
// and returns RISC-V extended load data or a fault code with a single-cycle done pulse.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iValid,
   input  logic        iMemRead,
   input  logic        iMemWrite,
   input  logic [2:0]  iFunct3,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWriteData,
   output logic        oBusy,
   output logic        oDone,
   output logic [31:0] oLoadData,
   output logic [2:0]  oFaultCode,
   output logic        oMemReq,
   output logic        oMemWe,
   output logic [31:0] oMemAddr,
   output logic [3:0]  oMemBe,
   output logic [31:0] oMemWdata,
   input  logic        iMemAck,
   input  logic [31:0] iMemRdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} LsuState;

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

   LsuState     state;
   logic [2:0]  reqFunct3;
   logic [1:0]  reqAddrLow;
   logic        reqWrite;
   logic [7:0]  timeoutCount;

   logic        cmdPresent;
   logic        illegalFunct3;
   logic        misaligned;
   logic [2:0]  fault;
   logic [3:0]  byteEnable;
   logic [31:0] storeData;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadExtract;

   assign oBusy      = (state != IDLE);
   assign cmdPresent = iValid & (iMemRead | iMemWrite);

   // Decode the incoming command: fault classification, lane enables and replicated store data.
   always_comb begin
      illegalFunct3 = 1'b0;
      misaligned    = 1'b0;
      fault         = 3'd0;
      byteEnable    = 4'b1111;
      storeData     = 32'd0;

      if (iMemWrite)
         illegalFunct3 = iFunct3[2] | (iFunct3[1:0] == 2'b11);
      else
         illegalFunct3 = (iFunct3 == 3'b011) | (iFunct3[2:1] == 2'b11);

      misaligned = ((iFunct3[1:0] == 2'b01) & iAddress[0]) |
                   ((iFunct3[1:0] == 2'b10) & (iAddress[1:0] != 2'b00));

      if (iMemRead & iMemWrite)
         fault = 3'd3;
      else if (illegalFunct3)
         fault = 3'd2;
      else if (misaligned)
         fault = 3'd1;

      case (iFunct3[1:0])
         2'b00:   byteEnable = 4'b0001 << iAddress[1:0];
         2'b01:   byteEnable = iAddress[1] ? 4'b1100 : 4'b0011;
         default: byteEnable = 4'b1111;
      endcase

      if (iMemWrite) begin
         case (iFunct3[1:0])
            2'b00:   storeData = {4{iWriteData[7:0]}};
            2'b01:   storeData = {2{iWriteData[15:0]}};
            default: storeData = iWriteData;
         endcase
      end
   end

   // Lane selection uses the latched low address bits since iAddress may change during REQ.
   always_comb begin
      loadByte    = 8'd0;
      loadHalf    = reqAddrLow[1] ? iMemRdata[31:16] : iMemRdata[15:0];
      loadExtract = iMemRdata;

      case (reqAddrLow)
         2'b00:   loadByte = iMemRdata[7:0];
         2'b01:   loadByte = iMemRdata[15:8];
         2'b10:   loadByte = iMemRdata[23:16];
         default: loadByte = iMemRdata[31:24];
      endcase

      case (reqFunct3)
         3'b000:  loadExtract = {{24{loadByte[7]}}, loadByte};
         3'b100:  loadExtract = {24'd0, loadByte};
         3'b001:  loadExtract = {{16{loadHalf[15]}}, loadHalf};
         3'b101:  loadExtract = {16'd0, loadHalf};
         default: loadExtract = iMemRdata;
      endcase
   end

   // Transaction FSM; faulted commands skip REQ entirely, and an ack beats a same-edge timeout.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state        <= IDLE;
         reqFunct3    <= 3'd0;
         reqAddrLow   <= 2'd0;
         reqWrite     <= 1'b0;
         timeoutCount <= 8'd0;
         oDone        <= 1'b0;
         oLoadData    <= 32'd0;
         oFaultCode   <= 3'd0;
         oMemReq      <= 1'b0;
         oMemWe       <= 1'b0;
         oMemAddr     <= 32'd0;
         oMemBe       <= 4'd0;
         oMemWdata    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               oDone <= 1'b0;
               if (cmdPresent) begin
                  reqFunct3  <= iFunct3;
                  reqAddrLow <= iAddress[1:0];
                  reqWrite   <= iMemWrite;
                  if (fault != 3'd0) begin
                     oFaultCode <= fault;
                     oDone      <= 1'b1;
                     state      <= DONE;
                  end else begin
                     oMemReq      <= 1'b1;
                     oMemWe       <= iMemWrite;
                     oMemAddr     <= {iAddress[31:2], 2'b00};
                     oMemBe       <= byteEnable;
                     oMemWdata    <= storeData;
                     timeoutCount <= 8'd0;
                     state        <= REQ;
                  end
               end
            end
            REQ: begin
               if (iMemAck) begin
                  oMemReq    <= 1'b0;
                  oFaultCode <= 3'd0;
                  oDone      <= 1'b1;
                  if (!reqWrite)
                     oLoadData <= loadExtract;
                  state <= DONE;
               end else if (timeoutCount == LAST_COUNT) begin
                  oMemReq    <= 1'b0;
                  oFaultCode <= 3'd4;
                  oDone      <= 1'b1;
                  state      <= DONE;
               end else begin
                  timeoutCount <= timeoutCount + 8'd1;
               end
            end
            DONE: begin
               oDone <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected completions, monitor
// checks request shape and completion results as the DUT presents them.
module tb_load_store_unit;

   typedef struct {
      logic [2:0]  code;
      logic [31:0] loadData;
      int          reqCycles;
      int          busyCycles;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } ExpT;

   logic        iClk = 1'b0;
   logic        iRstN = 1'b0;
   logic        iValid = 1'b0;
   logic        iMemRead = 1'b0;
   logic        iMemWrite = 1'b0;
   logic [2:0]  iFunct3 = 3'd0;
   logic [31:0] iAddress = 32'd0;
   logic [31:0] iWriteData = 32'd0;
   logic        oBusy;
   logic        oDone;
   logic [31:0] oLoadData;
   logic [2:0]  oFaultCode;
   logic        oMemReq;
   logic        oMemWe;
   logic [31:0] oMemAddr;
   logic [3:0]  oMemBe;
   logic [31:0] oMemWdata;
   logic        iMemAck = 1'b0;
   logic [31:0] iMemRdata = 32'd0;

   int          errors = 0;
   int          checks = 0;
   ExpT         expQ[$];
   int          ackDelay = 0;
   logic        strayAck = 1'b0;
   logic [31:0] memWord = 32'd0;

   load_store_unit #(.TIMEOUT(4)) dut (
      .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iMemRead(iMemRead),
      .iMemWrite(iMemWrite), .iFunct3(iFunct3), .iAddress(iAddress),
      .iWriteData(iWriteData), .oBusy(oBusy), .oDone(oDone), .oLoadData(oLoadData),
      .oFaultCode(oFaultCode), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
      .oMemBe(oMemBe), .oMemWdata(oMemWdata), .iMemAck(iMemAck), .iMemRdata(iMemRdata)
   );

   always #5 iClk = ~iClk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: acks after ackDelay request cycles (0 means never); strayAck forces ack.
   initial begin
      int ackCount = 0;
      forever begin
         @(negedge iClk);
         iMemRdata = memWord;
         if (oMemReq) begin
            ackCount++;
            iMemAck = strayAck || (ackDelay != 0 && ackCount == ackDelay);
         end else begin
            ackCount = 0;
            iMemAck = strayAck;
         end
      end
   end

   // Monitor: tracks request cycles and stability, checks each completion against the queue.
   initial begin
      int          reqCycles = 0;
      int          busyCycles = 0;
      logic        unstable = 1'b0;
      logic [31:0] capAddr = 32'd0;
      logic [31:0] capWdata = 32'd0;
      logic [3:0]  capBe = 4'd0;
      logic        capWe = 1'b0;
      ExpT         e;
      forever begin
         @(negedge iClk);
         if (!iRstN) begin
            reqCycles = 0;
            busyCycles = 0;
            unstable = 1'b0;
         end else begin
            busyCycles = oBusy ? busyCycles + 1 : 0;
            if (oMemReq) begin
               if (reqCycles == 0) begin
                  capAddr = oMemAddr; capWdata = oMemWdata; capBe = oMemBe; capWe = oMemWe;
               end else if (oMemAddr !== capAddr || oMemWdata !== capWdata ||
                            oMemBe !== capBe || oMemWe !== capWe) begin
                  unstable = 1'b1;
               end
               reqCycles++;
            end
            if (oDone) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_done", {31'd0, oDone}, 32'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("fault_code", {29'd0, oFaultCode}, {29'd0, e.code});
                  checkOutput("load_data", oLoadData, e.loadData);
                  checkOutput("req_cycles", reqCycles, e.reqCycles);
                  checkOutput("done_latency", busyCycles, e.busyCycles);
                  if (e.reqCycles != 0) begin
                     checkOutput("mem_addr", capAddr, e.addr);
                     checkOutput("mem_be", {28'd0, capBe}, {28'd0, e.be});
                     checkOutput("mem_wdata", capWdata, e.wdata);
                     checkOutput("mem_we", {31'd0, capWe}, {31'd0, e.we});
                     checkOutput("req_stable", {31'd0, unstable}, 32'd0);
                  end
               end
               reqCycles = 0;
               unstable = 1'b0;
            end
         end
      end
   end

   task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, input logic [31:0] word,
                                input logic [2:0] expCode, input logic [31:0] expLoad,
                                input int expReq, input logic [3:0] expBe,
                                input logic [31:0] expWdata);
      ExpT e;
      bit  idle = 0;
      e.code = expCode; e.loadData = expLoad; e.reqCycles = expReq;
      e.busyCycles = expReq + 1; e.addr = {addr[31:2], 2'b00};
      e.be = expBe; e.wdata = expWdata; e.we = wr;
      if (rd || wr) expQ.push_back(e);
      @(negedge iClk);
      ackDelay = delay; memWord = word;
      iMemRead = rd; iMemWrite = wr; iFunct3 = f3; iAddress = addr; iWriteData = wdata;
      iValid = 1'b1;
      @(posedge iClk);
      #1;
      iValid = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
      iAddress = 32'hFFFF_FFFF; iWriteData = 32'h5555_5555; iFunct3 = 3'b111;
      for (int i = 0; i < 40; i++) begin
         @(negedge iClk);
         if (!oBusy) begin idle = 1; break; end
      end
      if (!idle) checkOutput("busy_timeout", {31'd0, oBusy}, 32'd0);
   endtask

   initial begin
      #2;
      checkOutput("rst_busy", {31'd0, oBusy}, 32'd0);
      checkOutput("rst_done", {31'd0, oDone}, 32'd0);
      checkOutput("rst_req", {31'd0, oMemReq}, 32'd0);
      checkOutput("rst_load", oLoadData, 32'd0);
      checkOutput("rst_code", {29'd0, oFaultCode}, 32'd0);
      checkOutput("rst_addr", oMemAddr, 32'd0);
      checkOutput("rst_be_wdata", {oMemBe, oMemWdata[27:0]}, 32'd0);
      @(negedge iClk);
      iRstN = 1'b1;

      // Store byte, ack after 3 request cycles.
      applyStimulus(0, 1, 3'b000, 32'h103, 32'h0000_00A5, 3, 32'd0, 0, 32'd0, 3, 4'b1000, 32'hA5A5_A5A5);

      // Loads from word 0x80FF7F01 with immediate ack.
      applyStimulus(1, 0, 3'b000, 32'h200, 32'hDEAD_BEEF, 1, 32'h80FF_7F01, 0, 32'h0000_0001, 1, 4'b0001, 32'd0);
      applyStimulus(1, 0, 3'b000, 32'h201, 32'hDEAD_BEEF, 1, 32'h80FF_7F01, 0, 32'h0000_007F, 1, 4'b0010, 32'd0);
      applyStimulus(1, 0, 3'b000, 32'h202, 32'hDEAD_BEEF, 1, 32'h80FF_7F01, 0, 32'hFFFF_FFFF, 1, 4'b0100, 32'd0);
      applyStimulus(1, 0, 3'b100, 32'h202, 32'hDEAD_BEEF, 1, 32'h80FF_7F01, 0, 32'h0000_00FF, 1, 4'b0100, 32'd0);
      applyStimulus(1, 0, 3'b001, 32'h202, 32'hDEAD_BEEF, 1, 32'h80FF_7F01, 0, 32'hFFFF_80FF, 1, 4'b1100, 32'd0);
      applyStimulus(1, 0, 3'b101, 32'h202, 32'hDEAD_BEEF, 1, 32'h80FF_7F01, 0, 32'h0000_80FF, 1, 4'b1100, 32'd0);
      applyStimulus(1, 0, 3'b010, 32'h200, 32'hDEAD_BEEF, 1, 32'h80FF_7F01, 0, 32'h80FF_7F01, 1, 4'b1111, 32'd0);

      // Stores leave oLoadData untouched.
      applyStimulus(0, 1, 3'b010, 32'h204, 32'h1234_5678, 2, 32'h0BAD_0BAD, 0, 32'h80FF_7F01, 2, 4'b1111, 32'h1234_5678);
      applyStimulus(0, 1, 3'b001, 32'h206, 32'h0000_BEEF, 1, 32'h0BAD_0BAD, 0, 32'h80FF_7F01, 1, 4'b1100, 32'hBEEF_BEEF);

      // Faults: no request, done one cycle after accept.
      applyStimulus(1, 0, 3'b010, 32'h002, 32'd0, 1, 32'h0BAD_0BAD, 1, 32'h80FF_7F01, 0, 4'd0, 32'd0);
      applyStimulus(0, 1, 3'b001, 32'h005, 32'd0, 1, 32'h0BAD_0BAD, 1, 32'h80FF_7F01, 0, 4'd0, 32'd0);
      applyStimulus(1, 0, 3'b011, 32'h000, 32'd0, 1, 32'h0BAD_0BAD, 2, 32'h80FF_7F01, 0, 4'd0, 32'd0);
      applyStimulus(0, 1, 3'b100, 32'h000, 32'd0, 1, 32'h0BAD_0BAD, 2, 32'h80FF_7F01, 0, 4'd0, 32'd0);
      applyStimulus(1, 1, 3'b010, 32'h000, 32'd0, 1, 32'h0BAD_0BAD, 3, 32'h80FF_7F01, 0, 4'd0, 32'd0);
      applyStimulus(1, 1, 3'b111, 32'h001, 32'd0, 1, 32'h0BAD_0BAD, 3, 32'h80FF_7F01, 0, 4'd0, 32'd0);

      // Timeout with no ack, then ack landing on the final allowed edge.
      applyStimulus(1, 0, 3'b010, 32'h300, 32'd0, 0, 32'hCAFE_F00D, 4, 32'h80FF_7F01, 4, 4'b1111, 32'd0);
      applyStimulus(1, 0, 3'b010, 32'h300, 32'd0, 4, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4, 4'b1111, 32'd0);

      // Asynchronous reset during the second request cycle.
      @(negedge iClk);
      ackDelay = 0;
      iMemRead = 1'b1; iFunct3 = 3'b010; iAddress = 32'h400; iValid = 1'b1;
      @(posedge iClk);
      #1;
      iValid = 1'b0; iMemRead = 1'b0;
      @(posedge iClk);
      #1;
      checkOutput("req_before_reset", {31'd0, oMemReq}, 32'd1);
      #1;
      iRstN = 1'b0;
      #1;
      checkOutput("reset_req", {31'd0, oMemReq}, 32'd0);
      checkOutput("reset_busy", {31'd0, oBusy}, 32'd0);
      checkOutput("reset_done", {31'd0, oDone}, 32'd0);
      checkOutput("reset_load", oLoadData, 32'd0);
      @(negedge iClk);
      iRstN = 1'b1;
      applyStimulus(1, 0, 3'b010, 32'h400, 32'd0, 2, 32'h1122_3344, 0, 32'h1122_3344, 2, 4'b1111, 32'd0);

      // Stray ack in IDLE and iValid with no command must do nothing.
      @(negedge iClk);
      strayAck = 1'b1;
      repeat (3) @(negedge iClk);
      strayAck = 1'b0;
      checkOutput("stray_ack_busy", {31'd0, oBusy}, 32'd0);
      iValid = 1'b1; iFunct3 = 3'b010; iAddress = 32'h500;
      @(posedge iClk);
      #1;
      iValid = 1'b0;
      checkOutput("no_cmd_busy", {31'd0, oBusy}, 32'd0);
      repeat (3) @(negedge iClk);
      checkOutput("no_cmd_req", {31'd0, oMemReq}, 32'd0);
      checkOutput("idle_load_kept", oLoadData, 32'h1122_3344);
      checkOutput("queue_empty", expQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
